qspi_master: RTL and testbench
==============================

QSPI_MASTER -- requirements
Module: qspi_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 1, meaning clk cycles per qspi_clk half-period (legal 1..255).
REQ-002 SHALL have ports, clock and reset first:
- clk  in  1  system clock
- reset  in  1  reset
- start  in  1  one-cycle transfer request
- cmd  in  8  command byte
- rd  in  1  1 = read data phase, 0 = write data phase
- len  in  8  data bytes after command (0 = command only)
- tx_data  in  8  write byte
- tx_valid  in  1  tx_data valid
- tx_ready  out  1  tx_data consumed this cycle
- rx_data  out  8  read byte
- rx_valid  out  1  rx_data valid, one-cycle pulse
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse at transfer end
- qspi_clk  out  1  serial clock
- qspi_ncs  out  1  chip select, active low
- qspi_io_o  out  4  data out
- qspi_io_oe  out  1  data output enable
- qspi_io_i  in  4  data in
REQ-003 SHALL use one clock, clk; reset is synchronous and active-high.

Function
REQ-004 SHALL derive a tick every CLK_DIV clk cycles while busy; each tick toggles qspi_clk; qspi_clk idles low.
REQ-005 SHALL change qspi_io_o/qspi_io_oe only on ticks that drive qspi_clk low (falling) and sample qspi_io_i only on ticks that drive qspi_clk high (rising), capturing the pin value present at that clk edge.
REQ-006 SHALL implement states IDLE, SETUP, CMD, TURN, WRITE, READ, HOLD.
REQ-007 IDLE: start=1 latches cmd, rd, len; busy=1 next cycle; qspi_ncs=0; go to SETUP. start while busy SHALL be ignored.
REQ-008 SETUP: one half-period with qspi_clk low, qspi_io_oe=1, qspi_io_o=cmd[7:4]; then CMD.
REQ-009 CMD: two rising edges send cmd[7:4] then cmd[3:0]; then len=0 -> HOLD, rd=0 -> WRITE, rd=1 -> TURN.
REQ-010 Nibble order SHALL be high nibble first for every byte in both directions.
REQ-011 WRITE: tx_ready pulses one cycle when a byte is taken, no earlier than the falling half-period preceding its high nibble; two rising edges per byte; remaining count decrements per byte; count 0 -> HOLD.
REQ-012 WRITE underrun: if tx_valid=0 when a byte is needed, qspi_clk SHALL stay low, qspi_ncs low, no ticks consumed, until tx_valid=1.
REQ-013 TURN: qspi_io_oe=0 from the falling edge after the last command nibble; exactly one dummy qspi_clk period, no sampling; then READ.
REQ-014 READ: qspi_io_oe=0; first rising edge -> rx_data[7:4], second -> rx_data[3:0]; rx_valid pulses the clk cycle after the second sample; no backpressure.
REQ-015 HOLD: qspi_clk low, qspi_io_oe=0; qspi_ncs=1 after one half-period; one further full qspi_clk period of ncs high; then done pulses, busy=0, IDLE.
REQ-016 Byte counter SHALL be 8-bit; len=255 transfers exactly 255 bytes, no wrap.
REQ-017 start in the same cycle as done SHALL be ignored; start accepted from the following cycle.
REQ-018 qspi_io_oe SHALL never be 1 in TURN, READ, or while qspi_ncs=1.

Reset
REQ-019 reset=1 at any clk edge, including mid-transfer, SHALL force next cycle: IDLE, qspi_ncs=1, qspi_clk=0, qspi_io_oe=0, qspi_io_o=0, busy=0, done=0, tx_ready=0, rx_valid=0, rx_data=0; no done for an aborted transfer.
REQ-020 Reset SHALL override start in the same cycle.

Verification
REQ-021 CLK_DIV=1, start cmd=0xA5 rd=0 len=0 -> ncs low, rising-edge nibbles 0xA, 0x5, ncs high, one done pulse, zero tx_ready.
REQ-022 cmd=0x03 rd=0 len=2, tx 0x12,0x34 -> rising-edge nibbles 0,3,1,2,3,4; exactly two tx_ready pulses; done once.
REQ-023 cmd=0x0B rd=1 len=2, slave model drives 0xC,0xD,0xE,0xF -> oe=0 from turnaround, one dummy period, rx_valid twice with 0xCD then 0xEF.
REQ-024 Write len=1, tx_valid held low 10 cycles after SETUP -> qspi_clk frozen low, ncs low; resumes on tx_valid, nibbles correct.
REQ-025 reset asserted mid-READ -> next cycle ncs=1, oe=0, busy=0, no done; new start 0x9F read succeeds.
REQ-026 CLK_DIV=3 -> qspi_clk high/low each exactly 3 clk cycles; start during busy ignored.

Source files
------------

// File: rtl/qspi_master.sv
// Quad-SPI master: command byte, optional write or read data phase, nibble-wide transfers.
// qspi_clk runs at clk / (2 * CLK_DIV) while busy and idles low.
module qspi_master #(
   parameter int unsigned CLK_DIV = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] cmd,
   input  logic       rd,
   input  logic [7:0] len,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       busy,
   output logic       done,
   output logic       qspi_clk,
   output logic       qspi_ncs,
   output logic [3:0] qspi_io_o,
   output logic       qspi_io_oe,
   input  logic [3:0] qspi_io_i
);

   typedef enum logic [2:0] {
      StIdle, StSetup, StCmd, StTurn, StWrite, StRead, StHold
   } state_e;

   localparam logic [7:0] DivLast = 8'(CLK_DIV - 1);

   state_e     state_q, state_d;
   logic       sclk_q, sclk_d;
   logic       ncs_q, ncs_d;
   logic       oe_q, oe_d;
   logic [3:0] io_q, io_d;
   logic [7:0] sh_q, sh_d;
   logic [7:0] cnt_q, cnt_d;
   logic [7:0] div_q, div_d;
   logic       rd_q, rd_d;
   logic       nib_q, nib_d;
   logic       stall_q, stall_d;
   logic [1:0] hold_q, hold_d;
   logic [7:0] rx_data_q, rx_data_d;
   logic       rx_valid_q, rx_valid_d;
   logic       done_q, done_d;
   logic       tick, fetch, take, to_hold;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StIdle;
         sclk_q     <= 1'b0;
         ncs_q      <= 1'b1;
         oe_q       <= 1'b0;
         io_q       <= 4'd0;
         sh_q       <= 8'd0;
         cnt_q      <= 8'd0;
         div_q      <= 8'd0;
         rd_q       <= 1'b0;
         nib_q      <= 1'b0;
         stall_q    <= 1'b0;
         hold_q     <= 2'd0;
         rx_data_q  <= 8'd0;
         rx_valid_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         sclk_q     <= sclk_d;
         ncs_q      <= ncs_d;
         oe_q       <= oe_d;
         io_q       <= io_d;
         sh_q       <= sh_d;
         cnt_q      <= cnt_d;
         div_q      <= div_d;
         rd_q       <= rd_d;
         nib_q      <= nib_d;
         stall_q    <= stall_d;
         hold_q     <= hold_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         done_q     <= done_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      sclk_d     = sclk_q;
      ncs_d      = ncs_q;
      oe_d       = oe_q;
      io_d       = io_q;
      sh_d       = sh_q;
      cnt_d      = cnt_q;
      rd_d       = rd_q;
      nib_d      = nib_q;
      stall_d    = stall_q;
      hold_d     = hold_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      done_d     = 1'b0;
      fetch      = 1'b0;
      take       = 1'b0;
      to_hold    = 1'b0;
      // The divider is frozen during a write underrun so no half-period is consumed.
      tick  = (state_q != StIdle) && !stall_q && (div_q == DivLast);
      div_d = (state_q == StIdle || stall_q || tick) ? 8'd0 : div_q + 8'd1;

      unique case (state_q)
         StIdle: begin
            if (start && !done_q) begin
               state_d = StSetup;
               sh_d    = cmd;
               rd_d    = rd;
               cnt_d   = len;
               io_d    = cmd[7:4];
               oe_d    = 1'b1;
               ncs_d   = 1'b0;
               sclk_d  = 1'b0;
               nib_d   = 1'b0;
               stall_d = 1'b0;
               hold_d  = 2'd0;
            end
         end
         StSetup: begin
            if (tick) begin
               sclk_d  = 1'b1;
               state_d = StCmd;
            end
         end
         StCmd: begin
            if (tick) begin
               if (!sclk_q) begin
                  sclk_d = 1'b1;
               end else begin
                  sclk_d = 1'b0;
                  if (!nib_q) begin
                     io_d  = sh_q[3:0];
                     nib_d = 1'b1;
                  end else if (cnt_q == 8'd0) begin
                     to_hold = 1'b1;
                  end else if (rd_q) begin
                     state_d = StTurn;
                     oe_d    = 1'b0;
                  end else begin
                     state_d = StWrite;
                     fetch   = 1'b1;
                  end
               end
            end
         end
         StWrite: begin
            if (stall_q) begin
               fetch = 1'b1;
            end else if (tick) begin
               if (!sclk_q) begin
                  sclk_d = 1'b1;
               end else begin
                  sclk_d = 1'b0;
                  if (!nib_q) begin
                     io_d  = sh_q[3:0];
                     nib_d = 1'b1;
                  end else if (cnt_q == 8'd0) begin
                     to_hold = 1'b1;
                  end else begin
                     fetch = 1'b1;
                  end
               end
            end
         end
         StTurn: begin
            if (tick) begin
               sclk_d = !sclk_q;
               if (sclk_q) begin
                  state_d = StRead;
                  nib_d   = 1'b0;
               end
            end
         end
         StRead: begin
            if (tick) begin
               if (!sclk_q) begin
                  sclk_d = 1'b1;
                  sh_d   = {sh_q[3:0], qspi_io_i};
                  nib_d  = !nib_q;
                  if (nib_q) begin
                     rx_data_d  = {sh_q[3:0], qspi_io_i};
                     rx_valid_d = 1'b1;
                     cnt_d      = cnt_q - 8'd1;
                  end
               end else begin
                  sclk_d = 1'b0;
                  if (!nib_q && cnt_q == 8'd0) to_hold = 1'b1;
               end
            end
         end
         StHold: begin
            if (tick) begin
               hold_d = hold_q + 2'd1;
               if (hold_q == 2'd0) ncs_d = 1'b1;
               if (hold_q == 2'd2) begin
                  state_d = StIdle;
                  done_d  = 1'b1;
                  hold_d  = 2'd0;
               end
            end
         end
         default: state_d = StIdle;
      endcase

      // Next write byte goes on the bus at the falling edge before its high nibble.
      if (fetch) begin
         if (tx_valid) begin
            take    = 1'b1;
            sh_d    = tx_data;
            io_d    = tx_data[7:4];
            nib_d   = 1'b0;
            cnt_d   = cnt_q - 8'd1;
            stall_d = 1'b0;
         end else begin
            stall_d = 1'b1;
         end
      end

      if (to_hold) begin
         state_d = StHold;
         oe_d    = 1'b0;
         io_d    = 4'd0;
         hold_d  = 2'd0;
      end
   end

   always_comb begin
      busy       = (state_q != StIdle);
      tx_ready   = take && !reset;
      rx_data    = rx_data_q;
      rx_valid   = rx_valid_q;
      done       = done_q;
      qspi_clk   = sclk_q;
      qspi_ncs   = ncs_q;
      qspi_io_o  = io_q;
      qspi_io_oe = oe_q;
   end

endmodule

// File: tb/tb_qspi_master.sv
// Directed bench for qspi_master: CLK_DIV=1 instance for protocol scenarios,
// CLK_DIV=3 instance for clock timing and start filtering.
module tb_qspi_master;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic       start3 = 1'b0;
   logic [7:0] cmd = 8'd0;
   logic       rd = 1'b0;
   logic [7:0] len = 8'd0;
   logic [7:0] tx_data = 8'd0;
   logic       tx_valid = 1'b0;
   logic [3:0] qspi_io_i = 4'd0;

   logic       tx_ready, rx_valid, busy, done, qspi_clk, qspi_ncs, qspi_io_oe;
   logic [7:0] rx_data;
   logic [3:0] qspi_io_o;
   logic       tx_ready3, rx_valid3, busy3, done3, qspi_clk3, qspi_ncs3, qspi_io_oe3;
   logic [7:0] rx_data3;
   logic [3:0] qspi_io_o3;

   int         tests_run = 0;
   int         fails = 0;

   logic [3:0] wr_q[$];
   logic [7:0] rx_q[$];
   logic [3:0] rd_nibs[$];
   logic [7:0] tx_q[$];
   logic       tx_en = 1'b0;
   int         txr_cnt = 0;
   int         done_cnt = 0;
   int         oe_bad = 0;
   int         rise_cnt = 0;
   int         rise_total = 0;
   logic       oe_dummy = 1'b1;
   logic       prev_clk = 1'b0;

   always #5 clk = ~clk;

   qspi_master #(.CLK_DIV(1)) dut (
      .clk(clk), .reset(reset), .start(start), .cmd(cmd), .rd(rd), .len(len),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy), .done(done),
      .qspi_clk(qspi_clk), .qspi_ncs(qspi_ncs), .qspi_io_o(qspi_io_o),
      .qspi_io_oe(qspi_io_oe), .qspi_io_i(qspi_io_i)
   );

   qspi_master #(.CLK_DIV(3)) dut3 (
      .clk(clk), .reset(reset), .start(start3), .cmd(cmd), .rd(rd), .len(len),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready3),
      .rx_data(rx_data3), .rx_valid(rx_valid3), .busy(busy3), .done(done3),
      .qspi_clk(qspi_clk3), .qspi_ncs(qspi_ncs3), .qspi_io_o(qspi_io_o3),
      .qspi_io_oe(qspi_io_oe3), .qspi_io_i(qspi_io_i)
   );

   // Bus monitor and slave model; the slave presents nibble k after the (k+3)th rising edge.
   initial begin
      forever begin
         @(negedge clk);
         if (qspi_ncs) rise_cnt = 0;
         if (qspi_clk && !prev_clk) begin
            rise_cnt++;
            rise_total++;
            if (qspi_io_oe) wr_q.push_back(qspi_io_o);
            if (rise_cnt == 3) oe_dummy = qspi_io_oe;
            if (rise_cnt >= 3 && (rise_cnt - 3) < int'(rd_nibs.size()))
               qspi_io_i = rd_nibs[rise_cnt - 3];
         end
         prev_clk = qspi_clk;
         if (qspi_io_oe && qspi_ncs) oe_bad++;
         if (tx_ready) txr_cnt++;
         if (rx_valid) rx_q.push_back(rx_data);
         if (done) done_cnt++;
      end
   end

   // Write-data source: pops a byte after each observed tx_ready.
   initial begin
      logic took;
      forever begin
         @(negedge clk);
         took = tx_ready;
         @(posedge clk);
         #1;
         if (took && tx_q.size() > 0) void'(tx_q.pop_front());
         tx_valid = tx_en && (tx_q.size() > 0);
         tx_data  = (tx_q.size() > 0) ? tx_q[0] : 8'd0;
      end
   end

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation still running at %0t", $time);
      $fatal(1);
   end

   function automatic logic [31:0] pack_nibs();
      logic [31:0] p = '0;
      foreach (wr_q[i]) p = {p[27:0], wr_q[i]};
      return p;
   endfunction

   task automatic clear_logs();
      wr_q.delete();
      rx_q.delete();
      txr_cnt    = 0;
      done_cnt   = 0;
      oe_bad     = 0;
      rise_total = 0;
      oe_dummy   = 1'b1;
   endtask

   task automatic do_start(input logic [7:0] c, input logic r, input logic [7:0] l);
      @(posedge clk);
      #1;
      cmd   = c;
      rd    = r;
      len   = l;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int max_cycles, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < max_cycles && !ok; i++) begin
         @(negedge clk);
         if (done) ok = 1'b1;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      tests_run++;
      if (qspi_ncs !== 1'b1) begin fails++; $display("FAIL reset_ncs: got %b want 1", qspi_ncs); end
      tests_run++;
      if (qspi_clk !== 1'b0) begin fails++; $display("FAIL reset_clk: got %b want 0", qspi_clk); end
      tests_run++;
      if (qspi_io_oe !== 1'b0) begin fails++; $display("FAIL reset_oe: got %b want 0", qspi_io_oe); end
      tests_run++;
      if (qspi_io_o !== 4'h0) begin fails++; $display("FAIL reset_io: got %h want 0", qspi_io_o); end
      tests_run++;
      if ({busy, done, tx_ready, rx_valid} !== 4'b0000) begin
         fails++;
         $display("FAIL reset_flags: got busy/done/txr/rxv=%b want 0000",
                  {busy, done, tx_ready, rx_valid});
      end
      tests_run++;
      if (rx_data !== 8'h00) begin fails++; $display("FAIL reset_rxdata: got %h want 00", rx_data); end
      tests_run++;
      if (qspi_ncs3 !== 1'b1) begin fails++; $display("FAIL reset_ncs3: got %b want 1", qspi_ncs3); end
   endtask

   task automatic test_cmd_only();
      bit ok;
      clear_logs();
      do_start(8'hA5, 1'b0, 8'd0);
      tests_run++;
      if ({busy, qspi_ncs} !== 2'b10) begin
         fails++;
         $display("FAIL cmd_start: got busy/ncs=%b want 10", {busy, qspi_ncs});
      end
      wait_done(100, ok);
      tests_run++;
      if (!ok) begin fails++; $display("FAIL cmd_done_timeout: got no done want done"); end
      repeat (3) @(negedge clk);
      tests_run++;
      if (wr_q.size() != 2 || pack_nibs() !== 32'h0000_00A5) begin
         fails++;
         $display("FAIL cmd_nibbles: got %0d nibbles %h want 2 nibbles a5", wr_q.size(), pack_nibs());
      end
      tests_run++;
      if (txr_cnt != 0) begin fails++; $display("FAIL cmd_txready: got %0d want 0", txr_cnt); end
      tests_run++;
      if (done_cnt != 1) begin fails++; $display("FAIL cmd_done_count: got %0d want 1", done_cnt); end
      tests_run++;
      if ({qspi_ncs, busy, oe_bad != 0} !== 3'b100) begin
         fails++;
         $display("FAIL cmd_end_state: got ncs/busy/oe_bad=%b%b%0d want 1 0 0", qspi_ncs, busy, oe_bad);
      end
   endtask

   task automatic test_write();
      bit ok;
      clear_logs();
      tx_q.delete();
      tx_q.push_back(8'h12);
      tx_q.push_back(8'h34);
      tx_en = 1'b1;
      do_start(8'h03, 1'b0, 8'd2);
      wait_done(200, ok);
      tests_run++;
      if (!ok) begin fails++; $display("FAIL wr_done_timeout: got no done want done"); end
      repeat (3) @(negedge clk);
      tx_en = 1'b0;
      tests_run++;
      if (wr_q.size() != 6 || pack_nibs() !== 32'h0003_1234) begin
         fails++;
         $display("FAIL wr_nibbles: got %0d nibbles %h want 6 nibbles 031234", wr_q.size(), pack_nibs());
      end
      tests_run++;
      if (txr_cnt != 2) begin fails++; $display("FAIL wr_txready: got %0d want 2", txr_cnt); end
      tests_run++;
      if (done_cnt != 1) begin fails++; $display("FAIL wr_done_count: got %0d want 1", done_cnt); end
      tests_run++;
      if (oe_bad != 0) begin fails++; $display("FAIL wr_oe_ncs: got %0d want 0", oe_bad); end
   endtask

   task automatic test_read();
      bit ok;
      clear_logs();
      rd_nibs.delete();
      rd_nibs.push_back(4'hC);
      rd_nibs.push_back(4'hD);
      rd_nibs.push_back(4'hE);
      rd_nibs.push_back(4'hF);
      do_start(8'h0B, 1'b1, 8'd2);
      wait_done(200, ok);
      tests_run++;
      if (!ok) begin fails++; $display("FAIL rd_done_timeout: got no done want done"); end
      repeat (3) @(negedge clk);
      tests_run++;
      if (wr_q.size() != 2 || pack_nibs() !== 32'h0000_000B) begin
         fails++;
         $display("FAIL rd_cmd_nibbles: got %0d driven nibbles %h want 2 nibbles 0b",
                  wr_q.size(), pack_nibs());
      end
      tests_run++;
      if (oe_dummy !== 1'b0) begin fails++; $display("FAIL rd_dummy_oe: got %b want 0", oe_dummy); end
      tests_run++;
      if (rise_total != 7) begin fails++; $display("FAIL rd_rise_count: got %0d want 7", rise_total); end
      tests_run++;
      if (rx_q.size() != 2) begin
         fails++;
         $display("FAIL rd_rx_count: got %0d want 2", rx_q.size());
      end else if (rx_q[0] !== 8'hCD || rx_q[1] !== 8'hEF) begin
         fails++;
         $display("FAIL rd_rx_data: got %h %h want cd ef", rx_q[0], rx_q[1]);
      end
      tests_run++;
      if (done_cnt != 1) begin fails++; $display("FAIL rd_done_count: got %0d want 1", done_cnt); end
   endtask

   task automatic test_underrun();
      bit ok;
      int frozen;
      clear_logs();
      tx_q.delete();
      tx_q.push_back(8'h5A);
      tx_en = 1'b0;
      do_start(8'h02, 1'b0, 8'd1);
      repeat (6) @(negedge clk);
      frozen = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (qspi_clk !== 1'b0 || qspi_ncs !== 1'b0 || busy !== 1'b1) frozen++;
      end
      tests_run++;
      if (frozen != 0) begin fails++; $display("FAIL ur_frozen: got %0d bad cycles want 0", frozen); end
      tests_run++;
      if (rise_total != 2 || txr_cnt != 0) begin
         fails++;
         $display("FAIL ur_stall_edges: got rises=%0d txr=%0d want 2 0", rise_total, txr_cnt);
      end
      @(posedge clk);
      #1;
      tx_en = 1'b1;
      wait_done(200, ok);
      tests_run++;
      if (!ok) begin fails++; $display("FAIL ur_done_timeout: got no done want done"); end
      repeat (3) @(negedge clk);
      tx_en = 1'b0;
      tests_run++;
      if (wr_q.size() != 4 || pack_nibs() !== 32'h0000_025A) begin
         fails++;
         $display("FAIL ur_nibbles: got %0d nibbles %h want 4 nibbles 025a", wr_q.size(), pack_nibs());
      end
      tests_run++;
      if (txr_cnt != 1 || done_cnt != 1) begin
         fails++;
         $display("FAIL ur_counts: got txr=%0d done=%0d want 1 1", txr_cnt, done_cnt);
      end
   endtask

   task automatic test_reset_mid_read();
      bit ok;
      int d0;
      clear_logs();
      rd_nibs.delete();
      for (int i = 1; i <= 8; i++) rd_nibs.push_back(4'(i));
      do_start(8'h0B, 1'b1, 8'd4);
      ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         if (rise_cnt >= 5) ok = 1'b1;
      end
      tests_run++;
      if (!ok) begin fails++; $display("FAIL rst_read_timeout: got no read edges want 5"); end
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      tests_run++;
      if ({qspi_ncs, qspi_io_oe, busy, qspi_clk, rx_valid} !== 5'b10000) begin
         fails++;
         $display("FAIL rst_abort_state: got ncs/oe/busy/clk/rxv=%b want 10000",
                  {qspi_ncs, qspi_io_oe, busy, qspi_clk, rx_valid});
      end
      d0 = done_cnt;
      repeat (20) @(negedge clk);
      tests_run++;
      if (done_cnt != d0) begin fails++; $display("FAIL rst_no_done: got %0d want %0d", done_cnt, d0); end
      clear_logs();
      rd_nibs.delete();
      rd_nibs.push_back(4'h7);
      rd_nibs.push_back(4'h1);
      do_start(8'h9F, 1'b1, 8'd1);
      wait_done(200, ok);
      tests_run++;
      if (!ok) begin fails++; $display("FAIL rst_reread_timeout: got no done want done"); end
      repeat (3) @(negedge clk);
      tests_run++;
      if (rx_q.size() != 1) begin
         fails++;
         $display("FAIL rst_reread_count: got %0d want 1", rx_q.size());
      end else if (rx_q[0] !== 8'h71) begin
         fails++;
         $display("FAIL rst_reread_data: got %h want 71", rx_q[0]);
      end
      tests_run++;
      if (pack_nibs() !== 32'h0000_009F) begin
         fails++;
         $display("FAIL rst_reread_cmd: got %h want 9f", pack_nibs());
      end
   endtask

   task automatic test_clk_div3();
      logic [23:0] clk_seen, ncs_seen, done_seen, busy_seen;
      logic [7:0]  nib3;
      logic        prev;
      int          nrise, stray;
      clk_seen  = '0;
      ncs_seen  = '0;
      done_seen = '0;
      busy_seen = '0;
      nib3      = 8'd0;
      prev      = 1'b0;
      nrise     = 0;
      stray     = 0;
      @(posedge clk);
      #1;
      cmd    = 8'h5A;
      rd     = 1'b0;
      len    = 8'd0;
      start3 = 1'b1;
      @(posedge clk);
      #1;
      start3 = 1'b0;
      for (int k = 0; k < 24; k++) begin
         @(negedge clk);
         clk_seen[k]  = qspi_clk3;
         ncs_seen[k]  = qspi_ncs3;
         done_seen[k] = done3;
         busy_seen[k] = busy3;
         if (qspi_clk3 && !prev && qspi_io_oe3) begin
            nib3 = {nib3[3:0], qspi_io_o3};
            nrise++;
         end
         prev = qspi_clk3;
         if (tx_ready3 || rx_valid3) stray++;
         @(posedge clk);
         #1;
         // Second request while busy, third in the cycle done is high: both must be dropped.
         start3 = (k == 3 || k == 20);
      end
      start3 = 1'b0;
      tests_run++;
      if (clk_seen !== 24'h000E38) begin
         fails++;
         $display("FAIL div3_clk: got %h want 000e38", clk_seen);
      end
      tests_run++;
      if (ncs_seen !== 24'hFF8000) begin
         fails++;
         $display("FAIL div3_ncs: got %h want ff8000", ncs_seen);
      end
      tests_run++;
      if (done_seen !== 24'h200000) begin
         fails++;
         $display("FAIL div3_done: got %h want 200000", done_seen);
      end
      tests_run++;
      if (busy_seen !== 24'h1FFFFF) begin
         fails++;
         $display("FAIL div3_busy: got %h want 1fffff", busy_seen);
      end
      tests_run++;
      if (nrise != 2 || nib3 !== 8'h5A) begin
         fails++;
         $display("FAIL div3_nibbles: got %0d rises %h want 2 5a", nrise, nib3);
      end
      tests_run++;
      if (stray != 0 || rx_data3 !== 8'h00) begin
         fails++;
         $display("FAIL div3_stray: got pulses=%0d rx=%h want 0 00", stray, rx_data3);
      end
   endtask

   initial begin
      test_reset();
      test_cmd_only();
      test_write();
      test_read();
      test_underrun();
      test_reset_mid_read();
      test_clk_div3();
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule
